// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings, FSM states, default width.
package mdu_pkg;

   localparam int MDU_W = 32;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'b000,
      MDU_MULTU = 3'b001,
      MDU_DIV   = 3'b010,
      MDU_DIVU  = 3'b011,
      MDU_MTHI  = 3'b100,
      MDU_MTLO  = 3'b101
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } mdu_state_e;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign correction.
module mdu_negate #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] a,
   output logic [W-1:0] y
);

   assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mdu_hilo.sv
// Iterative radix-2 multiply / restoring divide with HI/LO registers for the EX stage.
// Divide support is compiled in only when MDU_DIV_EN is defined; otherwise DIV/DIVU act as NOP.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int N = MDU_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         mf_sel,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] HI,
   output logic [N-1:0] LO,
   output logic [N-1:0] R
);

   localparam int CW = $clog2(N + 1);

   mdu_state_e     state, state_nx;
   logic [CW-1:0]  cnt;
   logic [2*N-1:0] acc;     // product accumulator, or remainder:quotient pair
   logic [N-1:0]   opnd;    // multiplicand magnitude, or divisor magnitude
   logic           sgn_q;

   logic           op_mul, op_div, op_signed, accept;
   logic           neg_a, neg_b;
   logic [N-1:0]   mag_a, mag_b;
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_next, prod_fix;

   assign op_mul    = (op == MDU_MULT) || (op == MDU_MULTU);
   assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);

`ifdef MDU_DIV_EN
   logic           is_div, sgn_r, b_zero;
   logic [N:0]     div_sh, div_diff;
   logic [2*N-1:0] div_next;
   logic [N-1:0]   quo_fix, rem_fix;

   assign op_div = (op == MDU_DIV) || (op == MDU_DIVU);
   assign b_zero = (B == '0);
   // Divide by zero runs on the raw dividend so the remainder comes out equal to A.
   assign neg_a  = op_signed && A[N-1] && !(op_div && b_zero);

   assign div_sh   = acc[2*N-1:N-1];
   assign div_diff = div_sh - {1'b0, opnd};
   assign div_next = div_diff[N] ? {div_sh[N-1:0], acc[N-2:0], 1'b0}
                                 : {div_diff[N-1:0], acc[N-2:0], 1'b1};

   mdu_negate #(.W(N)) u_neg_quo (.neg(sgn_q), .a(acc[N-1:0]),   .y(quo_fix));
   mdu_negate #(.W(N)) u_neg_rem (.neg(sgn_r), .a(acc[2*N-1:N]), .y(rem_fix));
`else
   assign op_div = 1'b0;
   assign neg_a  = op_signed && A[N-1];
`endif

   assign neg_b  = op_signed && B[N-1];
   assign accept = (state == IDLE) && start && (op_mul || op_div);

   mdu_negate #(.W(N))   u_neg_a    (.neg(neg_a), .a(A),   .y(mag_a));
   mdu_negate #(.W(N))   u_neg_b    (.neg(neg_b), .a(B),   .y(mag_b));
   mdu_negate #(.W(2*N)) u_neg_prod (.neg(sgn_q), .a(acc), .y(prod_fix));

   assign mul_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : '0);
   assign mul_next = {mul_sum, acc[N-1:1]};

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (cnt == CW'(1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         acc   <= '0;
         opnd  <= '0;
         sgn_q <= 1'b0;
         HI    <= '0;
         LO    <= '0;
         done  <= 1'b0;
`ifdef MDU_DIV_EN
         is_div <= 1'b0;
         sgn_r  <= 1'b0;
`endif
      end else begin
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt <= CW'(N);
`ifdef MDU_DIV_EN
                  is_div <= op_div;
                  sgn_r  <= op_div && op_signed && A[N-1] && !b_zero;
                  sgn_q  <= op_signed && (A[N-1] ^ B[N-1]) && !(op_div && b_zero);
                  acc    <= op_div ? {{N{1'b0}}, mag_a} : {{N{1'b0}}, mag_b};
                  opnd   <= op_div ? mag_b : mag_a;
`else
                  sgn_q  <= op_signed && (A[N-1] ^ B[N-1]);
                  acc    <= {{N{1'b0}}, mag_b};
                  opnd   <= mag_a;
`endif
               end else if (start && op == MDU_MTHI) begin
                  HI <= A;
               end else if (start && op == MDU_MTLO) begin
                  LO <= A;
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
`ifdef MDU_DIV_EN
               acc <= is_div ? div_next : mul_next;
`else
               acc <= mul_next;
`endif
            end
            FIX: begin
`ifdef MDU_DIV_EN
               if (is_div) begin
                  HI <= rem_fix;
                  LO <= quo_fix;
               end else begin
                  {HI, LO} <= prod_fix;
               end
`else
               {HI, LO} <= prod_fix;
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign R    = mf_sel ? HI : LO;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo with a scoreboard of expected HI/LO results.
module tb_mdu_hilo;
   import mdu_pkg::*;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst_n, start, mf_sel;
   logic [2:0]   op;
   logic [N-1:0] A, B;
   logic         busy, done;
   logic [N-1:0] HI, LO, R;

   typedef struct packed {
      logic [N-1:0] hi;
      logic [N-1:0] lo;
   } res_t;

   res_t         sbq[$];
   int           checks = 0;
   int           fails  = 0;
   logic [N-1:0] m_hi = '0;
   logic [N-1:0] m_lo = '0;

   always #5 clk = ~clk;

   mdu_hilo #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
      .mf_sel(mf_sel), .busy(busy), .done(done), .HI(HI), .LO(LO), .R(R)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_md(input logic [2:0] o);
`ifdef MDU_DIV_EN
      return o <= 3'd3;
`else
      return o <= 3'd1;
`endif
   endfunction

   function automatic res_t model(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      res_t        r;
      longint      sa, sd;
      logic [63:0] p;
      r = {m_hi, m_lo};
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      case (o)
         MDU_MULT:  begin p = 64'(sa * sd); r = p; end
         MDU_MULTU: begin p = {32'b0, a} * {32'b0, b}; r = p; end
         MDU_DIV: begin
            if (b == '0) r = {a, {N{1'b1}}};
            else begin r.lo = N'(sa / sd); r.hi = N'(sa % sd); end
         end
         MDU_DIVU: begin
            if (b == '0) r = {a, {N{1'b1}}};
            else begin r.lo = a / b; r.hi = a % b; end
         end
         default: ;
      endcase
      return r;
   endfunction

   // Drives a request for the next edge; multiply/divide results go to the scoreboard.
   task automatic issue(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      start = 1'b1; op = o; A = a; B = b;
      if (is_md(o)) sbq.push_back(model(o, a, b));
   endtask

   task automatic wait_result(input string tag, input int inj);
      int   cyc  = 0;
      int   bcnt = 0;
      res_t e;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && cyc < 100) begin
         if (busy) bcnt++;
         if (cyc == inj) begin
            start = 1'b1; op = MDU_MTLO; A = 32'h1;
         end else if (inj >= 0 && cyc == inj + 1) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      chk({tag, " latency"}, cyc, N + 1);
      chk({tag, " busy cycles"}, bcnt, N + 1);
      chk({tag, " busy in done cycle"}, busy, 0);
      if (sbq.size() == 0) begin
         chk({tag, " unexpected done"}, 1, 0);
      end else begin
         e = sbq.pop_front();
         chk({tag, " HI"}, HI, e.hi);
         chk({tag, " LO"}, LO, e.lo);
         m_hi = e.hi;
         m_lo = e.lo;
      end
   endtask

   // Ops that must not start the engine: MTHI/MTLO/NOP (and DIV when divide is absent).
   task automatic idle_op(input string tag, input logic [2:0] o, input logic [N-1:0] a);
      start = 1'b1; op = o; A = a; B = 32'h1;
      @(posedge clk); #1;
      start = 1'b0;
      if (o == MDU_MTHI) m_hi = a;
      if (o == MDU_MTLO) m_lo = a;
      chk({tag, " busy"}, busy, 0);
      chk({tag, " HI"}, HI, m_hi);
      chk({tag, " LO"}, LO, m_lo);
      @(posedge clk); #1;
      chk({tag, " busy later"}, busy, 0);
      chk({tag, " done"}, done, 0);
   endtask

   initial begin
      int   dcnt;
      logic [2:0]   rop;
      logic [N-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; op = '0; A = '0; B = '0; mf_sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset HI", HI, 0);
      chk("reset LO", LO, 0);
      chk("reset R", R, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(MDU_MULT, 32'hFFFFFFFF, 32'h2);
      wait_result("mult -1*2", -1);
      chk("mult -1*2 HI const", HI, 32'hFFFFFFFF);
      chk("mult -1*2 LO const", LO, 32'hFFFFFFFE);
      @(posedge clk); #1;
      chk("done pulse width", done, 0);

      issue(MDU_MULTU, 32'hFFFFFFFF, 32'h2);
      wait_result("multu", -1);
      chk("multu HI const", HI, 32'h00000001);

`ifdef MDU_DIV_EN
      issue(MDU_DIV, 32'hFFFFFFF9, 32'h2);
      wait_result("div -7/2", -1);
      chk("div -7/2 LO const", LO, 32'hFFFFFFFD);
      issue(MDU_DIVU, 32'h7, 32'h0);
      wait_result("divu 7/0", -1);
      issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_result("div min/-1", -1);
      chk("div min/-1 LO const", LO, 32'h80000000);
      issue(MDU_DIV, 32'hFFFFFFF9, 32'h0);
      wait_result("div -7/0", -1);
      issue(MDU_DIV, 32'd100, 32'hFFFFFFF9);
      wait_result("div 100/-7", -1);
`else
      idle_op("div disabled", MDU_DIV, 32'h55);
      idle_op("divu disabled", MDU_DIVU, 32'h66);
`endif

      for (int i = 0; i < 6; i++) begin
         rop = is_md(3'(i % 4)) ? 3'(i % 4) : 3'(i % 2);
         ra  = $urandom;
         rb  = (i == 5) ? 32'h0 : $urandom;
         issue(rop, ra, rb);
         wait_result($sformatf("rand%0d op%0d", i, rop), -1);
      end

      idle_op("mthi", MDU_MTHI, 32'h12345678);
      idle_op("mtlo", MDU_MTLO, 32'h9ABCDEF0);
      mf_sel = 1'b1; #1;
      chk("R sel HI", R, 32'h12345678);
      mf_sel = 1'b0; #1;
      chk("R sel LO", R, 32'h9ABCDEF0);
      idle_op("nop 110", 3'b110, 32'hDEAD0000);

      issue(MDU_MULT, 32'h00012345, 32'hFFFF0F0F);
      wait_result("mult with mtlo while busy", 5);

      issue(MDU_MULTU, 32'hCAFEBABE, 32'h0000F00D);
      wait_result("b2b first", -1);
      issue(MDU_MULT, 32'h80000000, 32'h80000000);
      wait_result("b2b second", -1);

`ifdef MDU_DIV_EN
      issue(MDU_DIV, 32'h7FFF1234, 32'h00000033);
`else
      issue(MDU_MULT, 32'h7FFF1234, 32'h00000033);
`endif
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("mid-op busy", busy, 1);
      rst_n = 1'b0; #1;
      chk("abort busy", busy, 0);
      chk("abort HI", HI, 0);
      chk("abort LO", LO, 0);
      sbq.delete();
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done || busy) dcnt++;
      end
      chk("no done after abort", dcnt, 0);

      issue(MDU_MULTU, 32'd1000, 32'd3000);
      wait_result("after abort", -1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
